data_memory_responder: RTL

- Responder end of the processor's memory bus: accepts single read/write requests from the CPU and returns read data with a one-cycle `ready` pulse.
- Supports byte-masked stores and a configurable wait-state counter.
- Decodes a memory-mapped IO page containing a LED output register and a free-running cycle counter.
- Sits beside program memory in the SOC and serves the CPU's memory-stage load/store traffic.

---
 rtl/data_memory_responder.sv | 117 +++++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: single-request memory-bus responder with byte-masked RAM, wait states and an IO page
// Ports:
//   CLK, RESET           clock and synchronous active-high reset
//   address, read        request byte address and read strobe, sampled while idle
//   write_mask           byte-lane write enables (nonzero means a store)
//   write_data           lane-aligned store data
//   read_data            response word, held until the next response
//   ready                one-cycle completion pulse
//   busy                 high from request acceptance until the response cycle ends
//   error                pulses with ready when the access is rejected
//   LEDS                 memory-mapped LED register (IO offset 0)
// Optional macro MISALIGN_CHECK_EN rejects unsupported mask shapes and misaligned halfword/word stores.
module data_memory_responder #(
    parameter int WORDS       = 256,
    parameter int WAIT_CYCLES = 1,
    parameter int IO_BIT      = 22
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] address,
    input  logic        read,
    input  logic [3:0]  write_mask,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        error,
    output logic [31:0] LEDS
);
    localparam int AW = $clog2(WORDS);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q, cycles, lookup, a;
    logic [3:0]  mask_q, wait_cnt;
    logic [31:0] mem [WORDS];
    logic        request, enter, bad, out_of_range, commit;

    assign request = read || (write_mask != 4'd0);
    assign busy    = state != S_IDLE;

    always_comb begin
        state_next = state;
        state_next = state == S_IDLE ? (request ? (WAIT_CYCLES == 0 ? S_RESPOND : S_WAIT) : S_IDLE) :
                     state == S_WAIT ? (wait_cnt == 4'd1 ? S_RESPOND : S_WAIT) : S_IDLE;
    end

    // The response word is captured on the edge that enters RESPOND; with no wait states that
    // edge is also the acceptance edge, so decode looks at the live request while idle.
    assign a            = state == S_IDLE ? address : addr_q;
    assign enter        = (state_next == S_RESPOND) && (state != S_RESPOND);
    assign out_of_range = !a[IO_BIT] && (a[31:2] >= 30'(WORDS));

`ifdef MISALIGN_CHECK_EN
    logic [3:0] m;
    logic       bad_mask, misaligned;
    assign m          = state == S_IDLE ? write_mask : mask_q;
    assign bad_mask   = !(m inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
    assign misaligned = (m == 4'b1111 && a[1:0] != 2'b00) || ((m == 4'b0011 || m == 4'b1100) && a[0]);
    assign bad        = out_of_range || bad_mask || misaligned;
`else
    logic unused_low;
    assign unused_low = ^a[1:0];
    assign bad        = out_of_range;
`endif

    // Counter reads report the value the counter holds during the RESPOND cycle.
    assign lookup = bad ? 32'd0 :
                    !a[IO_BIT] ? mem[a[AW+1:2]] :
                    a[3:2] == 2'd0 ? LEDS :
                    a[3:2] == 2'd1 ? cycles + 32'd1 : 32'd0;

    assign commit = state == S_RESPOND && !error && mask_q != 4'd0;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_IDLE;
            ready     <= 1'b0;
            error     <= 1'b0;
            read_data <= 32'd0;
            LEDS      <= 32'd0;
            cycles    <= 32'd0;
            wait_cnt  <= 4'd0;
            addr_q    <= 32'd0;
            mask_q    <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            state  <= state_next;
            cycles <= cycles + 32'd1;
            ready  <= enter;
            error  <= enter && bad;
            if (enter)
                read_data <= lookup;
            if (state == S_IDLE && request) begin
                addr_q   <= address;
                mask_q   <= write_mask;
                wdata_q  <= write_data;
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (commit && addr_q[IO_BIT] && addr_q[3:2] == 2'd0)
                for (int k = 0; k < 4; k++)
                    if (mask_q[k])
                        LEDS[8*k +: 8] <= wdata_q[8*k +: 8];
        end
    end

    // RAM is never cleared; a reset on the commit edge drops the store.
    always_ff @(posedge CLK) begin
        if (!RESET && commit && !addr_q[IO_BIT])
            for (int k = 0; k < 4; k++)
                if (mask_q[k])
                    mem[addr_q[AW+1:2]][8*k +: 8] <= wdata_q[8*k +: 8];
    end
endmodule
